// File: rtl/lolap_iter_if.sv
// lolap_iter_if: handshake bundle for the round-serial LolaP sequencer.
//   in_valid_i / in_ready_o / state_i    : input state transfer
//   out_valid_o / out_ready_i / state_o  : permuted state transfer
//   busy_o, round_o                      : status (high in RUN, 1-based round)
// The slave modport is the sequencer's view; master is the producer/consumer side.
interface lolap_iter_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [256:0] state_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [256:0] state_o;
    logic         busy_o;
    logic [3:0]   round_o;

    modport slave (
        input  in_valid_i, state_i, out_ready_i,
        output in_ready_o, out_valid_o, state_o, busy_o, round_o
    );

    modport master (
        output in_valid_i, state_i, out_ready_i,
        input  in_ready_o, out_valid_o, state_o, busy_o, round_o
    );
endinterface

// File: rtl/lolap_iter_ctrl.sv
// lolap_iter_ctrl: round-serial LolaP permutation sequencer.
// Accepts one 257-bit state, applies NR_ROUNDS rounds (one per clock) choosing
// the _w or _wo round variant per round from W_MASK, then holds the result
// until the consumer takes it.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : lolap_iter_if.slave (input/output handshakes, busy_o, round_o)

// Round variant without the round constant.
// round_o = rotl(x,7) ^ (x & rotl(x,1))
module LolaP_round_wo (
    input  logic [256:0] round_i,
    output logic [256:0] round_o
);
    assign round_o = {round_i[249:0], round_i[256:250]}
                   ^ (round_i & {round_i[255:0], round_i[256]});
endmodule

// Round variant with the round constant (bits 0 and 256 flipped).
// round_o = rotl(x,3) ^ (~x & rotl(x,5)) ^ RC
module LolaP_round_w (
    input  logic [256:0] round_i,
    output logic [256:0] round_o
);
    localparam logic [256:0] RC = {1'b1, 255'd0, 1'b1};

    assign round_o = {round_i[253:0], round_i[256:254]}
                   ^ (~round_i & {round_i[251:0], round_i[256:252]})
                   ^ RC;
endmodule

// FSM states
//   state   | meaning
//   S_IDLE  | waiting for an input state
//   S_RUN   | applying round rnd this cycle
//   S_DONE  | result valid on state_o, waiting for out_ready_i
module lolap_iter_ctrl #(
    parameter int                   NR_ROUNDS = 8,
    parameter logic [NR_ROUNDS-1:0] W_MASK    = 8'b1100_1101
) (
    input  logic         clk_i,
    input  logic         rst_i,
    lolap_iter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    // Zero-extended so the 4-bit round index addresses it without width games.
    localparam logic [15:0] W_MASK_EXT = 16'(W_MASK);
    localparam logic [3:0]  LAST_RND   = 4'(NR_ROUNDS);

    fsm_t         fsm;
    logic [256:0] st;
    logic [3:0]   rnd;
    logic [256:0] st_w;
    logic [256:0] st_wo;
    logic [256:0] next_st;
    logic         accept;

    LolaP_round_w  u_round_w  (.round_i(st), .round_o(st_w));
    LolaP_round_wo u_round_wo (.round_i(st), .round_o(st_wo));

    assign next_st = W_MASK_EXT[rnd - 4'd1] ? st_w : st_wo;

    // DONE with out_ready_i lets the next state in on the same edge the
    // result leaves, so back-to-back operations have no idle bubble.
    assign bus.in_ready_o  = (fsm == S_IDLE) || ((fsm == S_DONE) && bus.out_ready_i);
    assign accept          = bus.in_valid_i && bus.in_ready_o;
    assign bus.out_valid_o = (fsm == S_DONE);
    assign bus.busy_o      = (fsm == S_RUN);
    assign bus.round_o     = rnd;
    assign bus.state_o     = st;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm <= S_IDLE;
            st  <= '0;
            rnd <= '0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (accept) begin
                        st  <= bus.state_i;
                        rnd <= 4'd1;
                        fsm <= S_RUN;
                    end
                end
                S_RUN: begin
                    st <= next_st;
                    if (rnd == LAST_RND) begin
                        rnd <= '0;
                        fsm <= S_DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready_i) begin
                        if (bus.in_valid_i) begin
                            st  <= bus.state_i;
                            rnd <= 4'd1;
                            fsm <= S_RUN;
                        end else begin
                            fsm <= S_IDLE;
                        end
                    end
                end
                default: begin
                    fsm <= S_IDLE;
                    rnd <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lolap_iter_ctrl.sv
// Testbench for lolap_iter_ctrl: default-parameter instance plus NR_ROUNDS=1
// and NR_ROUNDS=3 instances, checked against a bit-level permutation model.
module tb_lolap_iter_ctrl;
    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    lolap_iter_if if8 ();
    lolap_iter_if if1 ();
    lolap_iter_if if3 ();

    lolap_iter_ctrl dut8 (.clk_i(clk_i), .rst_i(rst_i), .bus(if8));
    lolap_iter_ctrl #(.NR_ROUNDS(1), .W_MASK(1'b1))   dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(if1));
    lolap_iter_ctrl #(.NR_ROUNDS(3), .W_MASK(3'b010)) dut3 (.clk_i(clk_i), .rst_i(rst_i), .bus(if3));

    int tests = 0;
    int fails = 0;
    int cur = 8;

    logic         c_in_ready, c_out_valid, c_busy;
    logic [3:0]   c_round;
    logic [256:0] c_state;

    always_comb begin
        c_in_ready  = if8.in_ready_o;
        c_out_valid = if8.out_valid_o;
        c_busy      = if8.busy_o;
        c_round     = if8.round_o;
        c_state     = if8.state_o;
        if (cur == 1) begin
            c_in_ready  = if1.in_ready_o;
            c_out_valid = if1.out_valid_o;
            c_busy      = if1.busy_o;
            c_round     = if1.round_o;
            c_state     = if1.state_o;
        end else if (cur == 3) begin
            c_in_ready  = if3.in_ready_o;
            c_out_valid = if3.out_valid_o;
            c_busy      = if3.busy_o;
            c_round     = if3.round_o;
            c_state     = if3.state_o;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [256:0] m_wo(input logic [256:0] x);
        logic [256:0] y;
        for (int i = 0; i < 257; i++)
            y[i] = x[(i + 250) % 257] ^ (x[i] & x[(i + 256) % 257]);
        return y;
    endfunction

    function automatic logic [256:0] m_w(input logic [256:0] x);
        logic [256:0] y;
        for (int i = 0; i < 257; i++)
            y[i] = x[(i + 254) % 257] ^ (~x[i] & x[(i + 252) % 257]) ^ ((i == 0) || (i == 256));
        return y;
    endfunction

    function automatic logic [256:0] perm(input logic [256:0] x, input int nr, input logic [15:0] mask);
        logic [256:0] y;
        y = x;
        for (int r = 1; r <= nr; r++)
            y = mask[r-1] ? m_w(y) : m_wo(y);
        return y;
    endfunction

    function automatic logic [256:0] rand257();
        logic [256:0] v;
        v = '0;
        for (int i = 0; i < 9; i++)
            v = (v << 32) | 257'($urandom());
        return v;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [256:0] act, input logic [256:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [256:0] d, input logic r);
        if (cur == 1) begin
            if1.in_valid_i = v; if1.state_i = d; if1.out_ready_i = r;
        end else if (cur == 3) begin
            if3.in_valid_i = v; if3.state_i = d; if3.out_ready_i = r;
        end else begin
            if8.in_valid_i = v; if8.state_i = d; if8.out_ready_i = r;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset(input string name);
        chk({name, " in_ready"},  257'(c_in_ready),  257'd1);
        chk({name, " out_valid"}, 257'(c_out_valid), 257'd0);
        chk({name, " busy"},      257'(c_busy),      257'd0);
        chk({name, " round"},     257'(c_round),     257'd0);
        chk({name, " state_o"},   c_state,           257'd0);
    endtask

    // One full operation with out_ready_i held high; checks latency,
    // round_o stepping, busy_o and the result.
    task automatic run_op(input string name, input logic [256:0] din,
                          input logic [256:0] exp, input int nr);
        drive(1'b1, din, 1'b1);
        #1;
        chk({name, " in_ready idle"}, 257'(c_in_ready), 257'd1);
        step();
        drive(1'b0, din, 1'b1);
        for (int k = 1; k <= nr; k++) begin
            chk($sformatf("%s busy r%0d", name, k),  257'(c_busy),      257'd1);
            chk($sformatf("%s round r%0d", name, k), 257'(c_round),     257'(k));
            chk($sformatf("%s early valid r%0d", name, k), 257'(c_out_valid), 257'd0);
            step();
        end
        chk({name, " out_valid"}, 257'(c_out_valid), 257'd1);
        chk({name, " busy done"}, 257'(c_busy),      257'd0);
        chk({name, " round done"}, 257'(c_round),    257'd0);
        chk({name, " result"},    c_state,           exp);
        step();
        chk({name, " idle after"}, 257'(c_out_valid), 257'd0);
    endtask

    typedef struct {
        string        name;
        logic [256:0] din;
        logic [256:0] exp;
    } vec_t;

    vec_t         vecs [0:3];
    logic [256:0] sd   [0:20];
    logic [256:0] sexp [0:20];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [256:0] alt;
        logic [256:0] din;
        logic [256:0] exp;
        int vcount;

        alt = '0;
        for (int i = 0; i < 257; i += 2) alt[i] = 1'b1;
        vecs[0] = '{"zero",    257'd0,             257'd0};
        vecs[1] = '{"msb_lsb", {1'b1, 256'h1},     257'd0};
        vecs[2] = '{"ones",    {257{1'b1}},        257'd0};
        vecs[3] = '{"alt",     alt,                257'd0};
        for (int i = 0; i < 4; i++) vecs[i].exp = perm(vecs[i].din, 8, 16'hCD);

        if8.in_valid_i = 0; if8.state_i = '0; if8.out_ready_i = 0;
        if1.in_valid_i = 0; if1.state_i = '0; if1.out_ready_i = 0;
        if3.in_valid_i = 0; if3.state_i = '0; if3.out_ready_i = 0;

        // Reset asserted before any clock edge: async effect.
        rst_i = 1'b1;
        #3;
        cur = 8; #0 chk_reset("rst dut8");
        cur = 1; #1 chk_reset("rst dut1");
        cur = 3; #1 chk_reset("rst dut3");
        cur = 8;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;

        // Table-driven single operations.
        for (int i = 0; i < 4; i++)
            run_op(vecs[i].name, vecs[i].din, vecs[i].exp, 8);

        // Back-to-back stream: one result every 9 cycles.
        for (int j = 0; j < 21; j++) begin
            sd[j]   = rand257();
            sexp[j] = perm(sd[j], 8, 16'hCD);
        end
        drive(1'b1, sd[0], 1'b1);
        step();
        for (int j = 0; j < 20; j++) begin
            for (int k = 1; k <= 8; k++) begin
                if (k == 1) drive(j < 19, sd[j+1], 1'b1);
                chk($sformatf("stream %0d round %0d", j, k), 257'(c_round), 257'(k));
                step();
            end
            chk($sformatf("stream %0d valid", j), 257'(c_out_valid), 257'd1);
            chk($sformatf("stream %0d result", j), c_state, sexp[j]);
            chk($sformatf("stream %0d in_ready", j), 257'(c_in_ready), 257'd1);
            step();
        end
        chk("stream end valid", 257'(c_out_valid), 257'd0);
        chk("stream end busy",  257'(c_busy),      257'd0);

        // Backpressure for 5 cycles with a competing input offered.
        din = rand257();
        exp = perm(din, 8, 16'hCD);
        drive(1'b1, din, 1'b0);
        step();
        drive(1'b0, din, 1'b0);
        for (int k = 0; k < 8; k++) step();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, rand257(), 1'b0);
            #1;
            chk($sformatf("bp valid %0d", k),    257'(c_out_valid), 257'd1);
            chk($sformatf("bp state %0d", k),    c_state,           exp);
            chk($sformatf("bp in_ready %0d", k), 257'(c_in_ready),  257'd0);
            step();
        end
        drive(1'b0, '0, 1'b1);
        #1;
        chk("bp release in_ready", 257'(c_in_ready), 257'd1);
        step();
        chk("bp after valid", 257'(c_out_valid), 257'd0);
        chk("bp after busy",  257'(c_busy),      257'd0);
        step();
        chk("bp no duplicate", 257'(c_out_valid), 257'd0);

        // Input activity during RUN is ignored.
        din = rand257();
        exp = perm(din, 8, 16'hCD);
        drive(1'b1, din, 1'b1);
        step();
        for (int k = 1; k <= 8; k++) begin
            drive(k[0], rand257(), 1'b1);
            #1;
            chk($sformatf("run in_ready %0d", k), 257'(c_in_ready), 257'd0);
            step();
        end
        chk("run ignore valid",  257'(c_out_valid), 257'd1);
        chk("run ignore result", c_state,           exp);
        drive(1'b0, '0, 1'b1);
        step();
        chk("run ignore idle", 257'(c_out_valid), 257'd0);

        // Reset mid-operation at round 4.
        din = rand257();
        drive(1'b1, din, 1'b1);
        step();
        drive(1'b0, din, 1'b1);
        step(); step(); step();
        chk("mid round4", 257'(c_round), 257'd4);
        #2 rst_i = 1'b1;
        #1 chk_reset("mid rst");
        step(); step();
        @(negedge clk_i);
        rst_i = 1'b0;
        vcount = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (c_out_valid) vcount++;
        end
        chk("mid no valid pulse", 257'(vcount), 257'd0);
        run_op("post reset", sd[20], sexp[20], 8);

        // Parameter sweep.
        cur = 1;
        run_op("nr1 a", {1'b1, 256'h1}, perm({1'b1, 256'h1}, 1, 16'h1), 1);
        din = rand257();
        run_op("nr1 b", din, perm(din, 1, 16'h1), 1);
        cur = 3;
        run_op("nr3 a", {1'b1, 256'h1}, perm({1'b1, 256'h1}, 3, 16'h2), 3);
        din = rand257();
        run_op("nr3 b", din, perm(din, 3, 16'h2), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
